// File: rtl/neighbor_fetch_pkg.sv
// Shared widths, direction and FSM types for the neighbour fetch unit.
// Direction order N,NE,E,SE,S,SW,W,NW matches surrounding_signals index.
package neighbor_fetch_pkg;

    localparam int X_bits      = 8;
    localparam int Y_bits      = 7;
    localparam int SIGNAL_bits = 8;

    typedef enum logic [2:0] {
        DIR_N,
        DIR_NE,
        DIR_E,
        DIR_SE,
        DIR_S,
        DIR_SW,
        DIR_W,
        DIR_NW
    } dir_e;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_e;

    localparam logic [3:0] LAST_IDX = 4'd8;

endpackage

// File: rtl/neighbor_fetch_if.sv
// Request, environment lookup and result bundle of the neighbour fetch unit.
// master = requester/environment side, slave = neighbor_fetch.
interface neighbor_fetch_if;
    import neighbor_fetch_pkg::*;

    logic                                start;
    logic [X_bits-1:0]                   center_x;
    logic [Y_bits-1:0]                   center_y;
    logic [X_bits-1:0]                   lookup_X;
    logic [Y_bits-1:0]                   lookup_Y;
    logic [SIGNAL_bits-1:0]              lookup_signal;
    logic                                lookup_sugar;
    logic                                busy;
    logic                                done;
    logic [7:0][SIGNAL_bits-1:0]         surrounding_signals;
    logic [SIGNAL_bits-1:0]              cur_signal;
    logic                                cur_sugar;

    modport master (
        output start, center_x, center_y,
        output lookup_signal, lookup_sugar,
        input  lookup_X, lookup_Y,
        input  busy, done,
        input  surrounding_signals, cur_signal, cur_sugar
    );

    modport slave (
        input  start, center_x, center_y,
        input  lookup_signal, lookup_sugar,
        output lookup_X, lookup_Y,
        output busy, done,
        output surrounding_signals, cur_signal, cur_sugar
    );

endinterface

// File: rtl/neighbor_addr.sv
// Cell address for fetch index 0 (center) or 1..8 (N..NW), Y grows south.
// NEIGHBOR_FETCH_WRAP_EN: toroidal wrap; otherwise clamp and flag offgrid.
module neighbor_addr
    import neighbor_fetch_pkg::*;
#(
    parameter int GRID_W = 160,
    parameter int GRID_H = 120
) (
    input  logic [X_bits-1:0] cx,
    input  logic [Y_bits-1:0] cy,
    input  logic [3:0]        idx,
    output logic [X_bits-1:0] x,
    output logic [Y_bits-1:0] y,
    output logic              offgrid
);

    localparam logic [X_bits-1:0] XMAX = X_bits'(GRID_W - 1);
    localparam logic [Y_bits-1:0] YMAX = Y_bits'(GRID_H - 1);
`ifdef NEIGHBOR_FETCH_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    dir_e dir;
    logic xdec, xinc, ydec, yinc;
    logic xoff, yoff;

    assign dir = dir_e'(3'(idx - 4'd1));

    always_comb begin
        xdec = 1'b0;
        xinc = 1'b0;
        ydec = 1'b0;
        yinc = 1'b0;
        if (idx != 4'd0) begin
            unique case (dir)
                DIR_N:  ydec = 1'b1;
                DIR_NE: begin xinc = 1'b1; ydec = 1'b1; end
                DIR_E:  xinc = 1'b1;
                DIR_SE: begin xinc = 1'b1; yinc = 1'b1; end
                DIR_S:  yinc = 1'b1;
                DIR_SW: begin xdec = 1'b1; yinc = 1'b1; end
                DIR_W:  xdec = 1'b1;
                DIR_NW: begin xdec = 1'b1; ydec = 1'b1; end
                default: ;
            endcase
        end
    end

    always_comb begin
        x    = cx;
        xoff = 1'b0;
        if (xdec) begin
            if (cx == '0) begin
                x    = WRAP ? XMAX : '0;
                xoff = !WRAP;
            end else begin
                x = cx - 1'b1;
            end
        end else if (xinc) begin
            if (cx == XMAX) begin
                x    = WRAP ? '0 : XMAX;
                xoff = !WRAP;
            end else begin
                x = cx + 1'b1;
            end
        end
    end

    always_comb begin
        y    = cy;
        yoff = 1'b0;
        if (ydec) begin
            if (cy == '0) begin
                y    = WRAP ? YMAX : '0;
                yoff = !WRAP;
            end else begin
                y = cy - 1'b1;
            end
        end else if (yinc) begin
            if (cy == YMAX) begin
                y    = WRAP ? '0 : YMAX;
                yoff = !WRAP;
            end else begin
                y = cy + 1'b1;
            end
        end
    end

    assign offgrid = xoff | yoff;

endmodule

// File: rtl/neighbor_fetch.sv
// Fetches the center cell and its 8 neighbours through a 1-cycle lookup port.
// Edge behaviour selected by NEIGHBOR_FETCH_WRAP_EN (see neighbor_addr).
module neighbor_fetch
    import neighbor_fetch_pkg::*;
#(
    parameter int GRID_W = 160,
    parameter int GRID_H = 120
) (
    input logic            newLocClock,
    input logic            RESET_SIM,
    neighbor_fetch_if.slave bus
);

    state_e state_q, state_d;

    logic [X_bits-1:0]        cx_q;
    logic [Y_bits-1:0]        cy_q;
    logic [3:0]               idx_q;
    logic [X_bits-1:0]        lx_q;
    logic [Y_bits-1:0]        ly_q;

    logic                     iss_vld_q;
    logic [3:0]               iss_idx_q;
    logic                     iss_off_q;
    logic                     rd_vld_q;
    logic [3:0]               rd_idx_q;
    logic                     rd_off_q;

    logic [7:0][SIGNAL_bits-1:0] surr_q;
    logic [SIGNAL_bits-1:0]   cur_sig_q;
    logic                     cur_sug_q;

    logic                     accept;
    logic                     issue;
    logic [3:0]               issue_idx;
    logic [X_bits-1:0]        a_cx;
    logic [Y_bits-1:0]        a_cy;
    logic [X_bits-1:0]        a_x;
    logic [Y_bits-1:0]        a_y;
    logic                     a_off;
    logic [2:0]               sidx;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        issue     = 1'b0;
        issue_idx = 4'd0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FETCH;
                    accept  = 1'b1;
                    issue   = 1'b1;
                end
            end
            FETCH: begin
                issue     = 1'b1;
                issue_idx = idx_q + 4'd1;
                if (issue_idx == LAST_IDX) state_d = DRAIN;
            end
            DRAIN: begin
                if (rd_vld_q && rd_idx_q == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    state_d = FETCH;
                    accept  = 1'b1;
                    issue   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Index 0 is issued on the accepting edge, before the center is latched.
    assign a_cx = accept ? bus.center_x : cx_q;
    assign a_cy = accept ? bus.center_y : cy_q;

    neighbor_addr #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_addr (
        .cx      (a_cx),
        .cy      (a_cy),
        .idx     (issue_idx),
        .x       (a_x),
        .y       (a_y),
        .offgrid (a_off)
    );

    assign sidx = 3'(rd_idx_q - 4'd1);

    always_ff @(posedge newLocClock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            state_q   <= IDLE;
            cx_q      <= '0;
            cy_q      <= '0;
            idx_q     <= '0;
            lx_q      <= '0;
            ly_q      <= '0;
            iss_vld_q <= 1'b0;
            iss_idx_q <= '0;
            iss_off_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_idx_q  <= '0;
            rd_off_q  <= 1'b0;
            surr_q    <= '0;
            cur_sig_q <= '0;
            cur_sug_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cx_q <= bus.center_x;
                cy_q <= bus.center_y;
            end
            if (issue) begin
                lx_q  <= a_x;
                ly_q  <= a_y;
                idx_q <= issue_idx;
            end
            iss_vld_q <= issue;
            iss_idx_q <= issue_idx;
            iss_off_q <= a_off;
            rd_vld_q  <= iss_vld_q;
            rd_idx_q  <= iss_idx_q;
            rd_off_q  <= iss_off_q;
            if (rd_vld_q) begin
                if (rd_idx_q == 4'd0) begin
                    cur_sig_q <= bus.lookup_signal;
                    cur_sug_q <= bus.lookup_sugar;
                end else begin
                    surr_q[sidx] <= rd_off_q ? '0 : bus.lookup_signal;
                end
            end
        end
    end

    assign bus.lookup_X            = lx_q;
    assign bus.lookup_Y            = ly_q;
    assign bus.busy                = (state_q == FETCH) || (state_q == DRAIN);
    assign bus.done                = (state_q == DONE);
    assign bus.surrounding_signals = surr_q;
    assign bus.cur_signal          = cur_sig_q;
    assign bus.cur_sugar           = cur_sug_q;

endmodule

// File: tb/tb_neighbor_fetch.sv
// Self-checking bench for neighbor_fetch with a registered environment model.
// Follows NEIGHBOR_FETCH_WRAP_EN for its reference neighbour rules.
module tb_neighbor_fetch;
    import neighbor_fetch_pkg::*;

    localparam int GW = 160;
    localparam int GH = 120;

    logic clk = 1'b0;
    logic rst = 1'b0;

    neighbor_fetch_if bus();

    neighbor_fetch #(
        .GRID_W (GW),
        .GRID_H (GH)
    ) dut (
        .newLocClock (clk),
        .RESET_SIM   (rst),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int env_mode = 0;
    int unsigned salt = 0;

    int DX[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int DY[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    int seen_x[9];
    int seen_y[9];

    function automatic logic [7:0] env_sig(int x, int y);
        case (env_mode)
            0:       return 8'((x % 16) * 16 + (y % 16));
            1:       return 8'h3F;
            default: return 8'(x * 7 + y * 13 + int'(salt));
        endcase
    endfunction

    function automatic logic env_sug(int x, int y);
        return 1'((x + y + int'(salt)) % 2);
    endfunction

    // Environment memory: read data one cycle after the address.
    always @(posedge clk) begin
        bus.lookup_signal <= env_sig(int'(bus.lookup_X), int'(bus.lookup_Y));
        bus.lookup_sugar  <= env_sug(int'(bus.lookup_X), int'(bus.lookup_Y));
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ref_addr(int cx, int cy, int k,
                            output int nx, output int ny, output bit off);
        int dx, dy;
        dx = 0;
        dy = 0;
        if (k > 0) begin
            dx = DX[k-1];
            dy = DY[k-1];
        end
        nx  = cx + dx;
        ny  = cy + dy;
        off = 1'b0;
`ifdef NEIGHBOR_FETCH_WRAP_EN
        nx = (nx + GW) % GW;
        ny = (ny + GH) % GH;
`else
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) off = 1'b1;
        if (nx < 0) nx = 0;
        if (nx >= GW) nx = GW - 1;
        if (ny < 0) ny = 0;
        if (ny >= GH) ny = GH - 1;
`endif
    endtask

    task automatic do_fetch(int cx, int cy, bit hold, bit pulse, bit rst_mid);
        int ex[9];
        int ey[9];
        bit eo[9];
        logic [7:0] es[9];
        logic esug;
        bit seen;
        for (int k = 0; k < 9; k++) begin
            ref_addr(cx, cy, k, ex[k], ey[k], eo[k]);
            es[k] = eo[k] ? 8'h00 : env_sig(ex[k], ey[k]);
        end
        esug = env_sug(ex[0], ey[0]);

        @(negedge clk);
        bus.start    = 1'b1;
        bus.center_x = X_bits'(cx);
        bus.center_y = Y_bits'(cy);
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.start    = 1'b0;
            bus.center_x = X_bits'($urandom_range(0, GW - 1));
            bus.center_y = Y_bits'($urandom_range(0, GH - 1));
        end
        for (int k = 0; k <= 10; k++) begin
            if (k <= 8) begin
                seen_x[k] = int'(bus.lookup_X);
                seen_y[k] = int'(bus.lookup_Y);
                chk("addr_x", 64'(bus.lookup_X), 64'(ex[k]));
                chk("addr_y", 64'(bus.lookup_Y), 64'(ey[k]));
            end
            chk("busy", 64'(bus.busy), 64'(k < 10));
            chk("done", 64'(bus.done), 64'(k == 10));
            if (rst_mid && k == 5) begin
                rst = 1'b1;
                #1;
                chk("rst_surr", 64'(bus.surrounding_signals), 64'(0));
                chk("rst_cur", 64'(bus.cur_signal), 64'(0));
                chk("rst_sugar", 64'(bus.cur_sugar), 64'(0));
                chk("rst_lx", 64'(bus.lookup_X), 64'(0));
                chk("rst_ly", 64'(bus.lookup_Y), 64'(0));
                chk("rst_busy", 64'(bus.busy), 64'(0));
                rst = 1'b0;
                seen = 1'b0;
                repeat (12) begin
                    @(posedge clk);
                    #1;
                    if (bus.done) seen = 1'b1;
                end
                chk("no_done_after_rst", 64'(seen), 64'(0));
                return;
            end
            if (pulse) bus.start = (k == 3 || k == 5);
            if (k < 10) begin
                @(posedge clk);
                #1;
            end
        end
        chk("cur_signal", 64'(bus.cur_signal), 64'(es[0]));
        chk("cur_sugar", 64'(bus.cur_sugar), 64'(esug));
        for (int d = 0; d < 8; d++)
            chk($sformatf("surr%0d", d), 64'(bus.surrounding_signals[d]), 64'(es[d+1]));
        if (!hold) begin
            salt = $urandom;
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            chk("done_once", 64'(bus.done), 64'(0));
            chk("idle_busy", 64'(bus.busy), 64'(0));
            chk("hold_lx", 64'(bus.lookup_X), 64'(ex[8]));
            chk("hold_ly", 64'(bus.lookup_Y), 64'(ey[8]));
            chk("stale_cur", 64'(bus.cur_signal), 64'(es[0]));
            for (int d = 0; d < 8; d++)
                chk($sformatf("stale%0d", d), 64'(bus.surrounding_signals[d]), 64'(es[d+1]));
        end
    endtask

    function automatic int pick(int lim);
        int r;
        r = int'($urandom_range(0, 3));
        if (r == 0) return 0;
        if (r == 1) return lim - 1;
        return int'($urandom_range(0, lim - 1));
    endfunction

    initial begin
        bus.start    = 1'b0;
        bus.center_x = '0;
        bus.center_y = '0;
        #2 rst = 1'b1;
        #2;
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_done", 64'(bus.done), 64'(0));
        chk("reset_lx", 64'(bus.lookup_X), 64'(0));
        chk("reset_ly", 64'(bus.lookup_Y), 64'(0));
        chk("reset_surr", 64'(bus.surrounding_signals), 64'(0));
        chk("reset_cur", 64'(bus.cur_signal), 64'(0));
        chk("reset_sugar", 64'(bus.cur_sugar), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        env_mode = 0;
        do_fetch(10, 10, 1'b0, 1'b0, 1'b0);
        chk("dir_N", 64'(bus.surrounding_signals[0]), 64'(8'hA9));
        chk("dir_E", 64'(bus.surrounding_signals[2]), 64'(8'hBA));
        chk("center", 64'(bus.cur_signal), 64'(8'hAA));

`ifdef NEIGHBOR_FETCH_WRAP_EN
        env_mode = 2;
        do_fetch(0, 0, 1'b0, 1'b0, 1'b0);
        chk("wrap_nw_x", 64'(seen_x[8]), 64'(159));
        chk("wrap_nw_y", 64'(seen_y[8]), 64'(119));
        chk("wrap_n_x", 64'(seen_x[1]), 64'(0));
        chk("wrap_n_y", 64'(seen_y[1]), 64'(119));
`else
        env_mode = 1;
        do_fetch(159, 119, 1'b0, 1'b0, 1'b0);
        chk("clamp_E", 64'(bus.surrounding_signals[2]), 64'(0));
        chk("clamp_SE", 64'(bus.surrounding_signals[3]), 64'(0));
        chk("clamp_S", 64'(bus.surrounding_signals[4]), 64'(0));
        chk("clamp_NE", 64'(bus.surrounding_signals[1]), 64'(0));
        chk("clamp_SW", 64'(bus.surrounding_signals[5]), 64'(0));
        chk("clamp_N", 64'(bus.surrounding_signals[0]), 64'(8'h3F));
        chk("clamp_W", 64'(bus.surrounding_signals[6]), 64'(8'h3F));
        chk("clamp_NW", 64'(bus.surrounding_signals[7]), 64'(8'h3F));
`endif

        env_mode = 2;
        do_fetch(pick(GW), pick(GH), 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++)
            do_fetch(pick(GW), pick(GH), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++)
            do_fetch(pick(GW), pick(GH), 1'b0, 1'b0, 1'b0);

        do_fetch(pick(GW), pick(GH), 1'b0, 1'b0, 1'b1);
        do_fetch(pick(GW), pick(GH), 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/neighbor_fetch.md
NEIGHBOR_FETCH -- requirements
Module: neighbor_fetch

Interface
REQ-001 SHALL have parameter GRID_W, default 160, grid width in cells (640 pixels / 4).
REQ-002 SHALL have parameter GRID_H, default 120, grid height in cells (480 pixels / 4).
REQ-003 SHALL have port newLocClock  in  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port RESET_SIM  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  request a fetch around center_x/center_y.
REQ-006 SHALL have port center_x  in  X_bits  center cell X; center_y  in  Y_bits  center cell Y.
REQ-007 SHALL have port lookup_X  out  X_bits  and lookup_Y  out  Y_bits  cell address driven to the environment lookup port.
REQ-008 SHALL have port lookup_signal  in  SIGNAL_bits  and lookup_sugar  in  1  environment read data, one cycle after the address.
REQ-009 SHALL have port busy  out  1  fetch in progress.
REQ-010 SHALL have port done  out  1  one-cycle pulse, results valid.
REQ-011 SHALL have port surrounding_signals  out  [8][SIGNAL_bits]  neighbour signals; index 0..7 = N,NE,E,SE,S,SW,W,NW.
REQ-012 SHALL have port cur_signal  out  SIGNAL_bits  and cur_sugar  out  1  center cell contents.

Function
REQ-013 SHALL implement states IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on start, FETCH->DRAIN after address index 8 is issued, DRAIN->DONE after the final capture, DONE->IDLE or DONE->FETCH (if start is high) after one cycle.
REQ-014 SHALL accept start only when busy is 0; start while busy SHALL be ignored.
REQ-015 SHALL latch center_x/center_y on the accepting edge E0; later changes SHALL not affect the fetch.
REQ-016 SHALL issue address index k (0=center, 1..8=N..NW) on lookup_X/lookup_Y as registered outputs after edge E_k.
REQ-017 SHALL capture the read data for index k at edge E_(k+2).
REQ-018 SHALL assert done for exactly the cycle after E_10, so done follows the accepting edge by 10 cycles.
REQ-019 SHALL hold busy high from after E0 through E_10, and low while done is high.
REQ-020 SHALL compute neighbour offsets with Y decreasing northward.
REQ-021 SHALL hold all result outputs stable from done until the next accepted start's E_2 capture; stale results are not zeroed.
REQ-022 SHALL hold lookup_X/lookup_Y at their last value while IDLE.

Reset
REQ-023 SHALL, on RESET_SIM, asynchronously enter IDLE and clear busy, done, lookup_X, lookup_Y, all surrounding_signals, cur_signal and cur_sugar to 0.
REQ-024 SHALL abandon a fetch when reset occurs mid-operation, and SHALL not pulse done for it.

Configuration
REQ-025 SHALL, with NEIGHBOR_FETCH_WRAP_EN defined, wrap the grid toroidally (x-1 at 0 -> GRID_W-1; x+1 at GRID_W-1 -> 0; likewise Y with GRID_H).
REQ-026 SHALL, without NEIGHBOR_FETCH_WRAP_EN, clamp off-grid addresses to the edge and capture 0 for every off-grid neighbour signal; timing is unchanged.

Structure
REQ-027 SHALL take X_bits, Y_bits and SIGNAL_bits from the shared params package, and SHALL define the direction enum (N..NW) and the FSM state typedef there.
REQ-028 SHALL place the offset and wrap/clamp arithmetic in one combinational sub-module, neighbor_addr (center, index -> x, y, offgrid).

Verification
REQ-029 Center (10,10), env returns signal = 16*x[3:0]+y[3:0] -> done 10 cycles after start; N=0xA9, E=0xBA, cur_signal=0xAA.
REQ-030 Wrap on, center (0,0) -> NW lookup address is (159,119); N address is (0,119).
REQ-031 Wrap off, center (159,119), env returns all 0x3F -> E, SE, S, NE, SW signals = 0; N, W, NW = 0x3F.
REQ-032 start pulsed at cycles 3 and 5 of a fetch -> both ignored; one done only.
REQ-033 start held high continuously -> done every 11 cycles with no gap in issuing.
REQ-034 RESET_SIM asserted at cycle 5 of a fetch -> outputs 0 immediately; no done; next start completes normally.
